// File: rtl/font_arbiter.sv
// Shares the single-port font glyph ROM between the display pipeline (full glyphs,
// strict priority) and a host port that reads back one glyph row per handshake.
module font_arbiter #(
    parameter int ADDR_W       = 7,
    parameter int GLYPH_W      = 128,
    parameter int ROW_W        = 8,
    parameter int STARVE_LIMIT = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               disp_req_i,
    input  logic [ADDR_W-1:0]  disp_char_i,
    output logic               disp_valid_o,
    output logic [GLYPH_W-1:0] disp_glyph_o,
    input  logic               host_req_i,
    input  logic [ADDR_W-1:0]  host_char_i,
    input  logic [3:0]         host_row_i,
    output logic               host_ack_o,
    output logic [ROW_W-1:0]   host_data_o,
    output logic               host_starve_o,
    output logic [ADDR_W-1:0]  font_addr_o,
    input  logic [GLYPH_W-1:0] font_dout_i
);

    localparam int ROWS  = GLYPH_W / ROW_W;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

    logic              w_grantDisp;
    logic              w_grantHost;
    logic [ADDR_W-1:0] w_grantChar;
    logic [CNT_W-1:0]  w_starveNext;
    logic [ROW_W-1:0]  w_rows [ROWS];

    logic              r_grantDisp;
    logic              r_grantHost;
    logic [ADDR_W-1:0] r_grantChar;
    logic [3:0]        r_grantRow;
    logic              r_s1Disp;
    logic              r_s1Host;
    logic [3:0]        r_s1Row;
    logic              r_s2Disp;
    logic              r_s2Host;
    logic [3:0]        r_s2Row;
    logic [ADDR_W-1:0] r_fontAddr;
    logic              r_hostAck;
    logic [ROW_W-1:0]  r_hostData;
    logic              r_hostPending;
    logic [CNT_W-1:0]  r_starveCnt;

    for (genvar g = 0; g < ROWS; g++) begin : g_rows
        assign w_rows[g] = font_dout_i[g*ROW_W +: ROW_W];
    end

    // Display always wins; the host may hold only one read in flight at a time.
    always_comb begin
        w_grantDisp  = disp_req_i;
        w_grantHost  = !disp_req_i && host_req_i && !r_hostPending;
        w_grantChar  = disp_req_i ? disp_char_i : host_char_i;
        w_starveNext = r_starveCnt;
        if (!host_req_i || w_grantHost) begin
            w_starveNext = '0;
        end else if (disp_req_i && !r_hostPending && (r_starveCnt != C_LIMIT)) begin
            w_starveNext = r_starveCnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_grantDisp   <= 1'b0;
            r_grantHost   <= 1'b0;
            r_grantChar   <= '0;
            r_grantRow    <= '0;
            r_s1Disp      <= 1'b0;
            r_s1Host      <= 1'b0;
            r_s1Row       <= '0;
            r_s2Disp      <= 1'b0;
            r_s2Host      <= 1'b0;
            r_s2Row       <= '0;
            r_fontAddr    <= '0;
            r_hostAck     <= 1'b0;
            r_hostData    <= '0;
            r_hostPending <= 1'b0;
            r_starveCnt   <= '0;
        end else begin
            r_grantDisp <= w_grantDisp;
            r_grantHost <= w_grantHost;
            if (w_grantDisp || w_grantHost) begin
                r_grantChar <= w_grantChar;
            end
            if (w_grantHost) begin
                r_grantRow <= host_row_i;
            end

            // Address launches one edge after the grant, with its stage-1 tags.
            if (r_grantDisp || r_grantHost) begin
                r_fontAddr <= r_grantChar;
            end
            r_s1Disp <= r_grantDisp;
            r_s1Host <= r_grantHost;
            r_s1Row  <= r_grantRow;
            r_s2Disp <= r_s1Disp;
            r_s2Host <= r_s1Host;
            r_s2Row  <= r_s1Row;

            r_hostAck <= r_s2Host;
            if (r_s2Host) begin
                r_hostData <= w_rows[r_s2Row];
            end

            if (w_grantHost) begin
                r_hostPending <= 1'b1;
            end else if (r_hostAck) begin
                r_hostPending <= 1'b0;
            end
            r_starveCnt <= w_starveNext;
        end
    end

    assign disp_valid_o  = r_s2Disp;
    assign disp_glyph_o  = font_dout_i;
    assign host_ack_o    = r_hostAck;
    assign host_data_o   = r_hostData;
    assign host_starve_o = (r_starveCnt == C_LIMIT);
    assign font_addr_o   = r_fontAddr;

endmodule

// File: tb/tb_font_arbiter.sv
// Self-checking bench for font_arbiter: directed scenarios plus random traffic,
// compared every cycle against a latency-based reference model and a ROM model.
module tb_font_arbiter;

    localparam int MAXC = 2048;

    logic         clk;
    logic         rst_i;
    logic         disp_req_i;
    logic [6:0]   disp_char_i;
    logic         disp_valid_o;
    logic [127:0] disp_glyph_o;
    logic         host_req_i;
    logic [6:0]   host_char_i;
    logic [3:0]   host_row_i;
    logic         host_ack_o;
    logic [7:0]   host_data_o;
    logic         host_starve_o;
    logic [6:0]   font_addr_o;
    logic [127:0] romDout;

    int total = 0;
    int bad   = 0;

    font_arbiter dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .disp_req_i    (disp_req_i),
        .disp_char_i   (disp_char_i),
        .disp_valid_o  (disp_valid_o),
        .disp_glyph_o  (disp_glyph_o),
        .host_req_i    (host_req_i),
        .host_char_i   (host_char_i),
        .host_row_i    (host_row_i),
        .host_ack_o    (host_ack_o),
        .host_data_o   (host_data_o),
        .host_starve_o (host_starve_o),
        .font_addr_o   (font_addr_o),
        .font_dout_i   (romDout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row r of character a is the byte {r, a[3:0]}.
    function automatic logic [127:0] glyphOf(input logic [6:0] a);
        logic [127:0] g;
        g = '0;
        for (int r = 0; r < 16; r++) begin
            g[r*8 +: 8] = {4'(r), a[3:0]};
        end
        return g;
    endfunction

    always @(posedge clk) romDout <= glyphOf(font_addr_o);

    // Reference model: events scheduled by edge number from the documented latencies.
    bit         expValid     [MAXC];
    logic [6:0] expValidChar [MAXC];
    bit         expAck       [MAXC];
    logic [7:0] expAckData   [MAXC];
    bit         expAddrLoad  [MAXC];
    logic [6:0] expAddrVal   [MAXC];

    int         edgeCnt    = 0;
    int         hostNextOk = 0;
    int         starveCnt  = 0;
    logic [6:0] addrCur    = '0;
    logic [7:0] hostDataCur = '0;
    bit         validNow   = 1'b0;
    logic [6:0] validCharNow = '0;
    bit         ackNow     = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            edgeCnt = edgeCnt + 1;
            if (edgeCnt + 6 >= MAXC) begin
                $display("[TB] FAIL model_overflow: edge %0d exceeds %0d", edgeCnt, MAXC);
                $fatal(1, "[TB] model table exhausted");
            end
            if (rst_i) begin
                for (int k = edgeCnt; k <= edgeCnt + 5; k++) begin
                    expValid[k]    = 1'b0;
                    expAck[k]      = 1'b0;
                    expAddrLoad[k] = 1'b0;
                end
                hostNextOk  = 0;
                starveCnt   = 0;
                addrCur     = '0;
                hostDataCur = '0;
                validNow    = 1'b0;
                ackNow      = 1'b0;
            end else begin
                bit gD, gH;
                gD = disp_req_i;
                gH = !disp_req_i && host_req_i && (edgeCnt >= hostNextOk);
                if (gD) begin
                    expAddrLoad[edgeCnt+1]  = 1'b1;
                    expAddrVal[edgeCnt+1]   = disp_char_i;
                    expValid[edgeCnt+2]     = 1'b1;
                    expValidChar[edgeCnt+2] = disp_char_i;
                end
                if (gH) begin
                    expAddrLoad[edgeCnt+1] = 1'b1;
                    expAddrVal[edgeCnt+1]  = host_char_i;
                    expAck[edgeCnt+3]      = 1'b1;
                    expAckData[edgeCnt+3]  = {host_row_i, host_char_i[3:0]};
                end
                if (!host_req_i || gH) begin
                    starveCnt = 0;
                end else if (disp_req_i && (edgeCnt >= hostNextOk) && (starveCnt < 8)) begin
                    starveCnt = starveCnt + 1;
                end
                if (gH) hostNextOk = edgeCnt + 5;
                if (expAddrLoad[edgeCnt]) addrCur = expAddrVal[edgeCnt];
                validNow     = expValid[edgeCnt];
                validCharNow = expValidChar[edgeCnt];
                ackNow       = expAck[edgeCnt];
                if (ackNow) hostDataCur = expAckData[edgeCnt];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        total = total + 1;
        if (observed !== expected) begin
            bad = bad + 1;
            $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h",
                     tag, edgeCnt, observed, expected);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            checkOutput("disp_valid", 128'(disp_valid_o), 128'(validNow));
            if (validNow) checkOutput("disp_glyph", disp_glyph_o, glyphOf(validCharNow));
            checkOutput("host_ack", 128'(host_ack_o), 128'(ackNow));
            checkOutput("host_data", 128'(host_data_o), 128'(hostDataCur));
            checkOutput("font_addr", 128'(font_addr_o), 128'(addrCur));
            checkOutput("host_starve", 128'(host_starve_o), 128'(starveCnt == 8));
        end
    end

    task automatic applyStimulus(input logic rst, input logic dreq, input logic [6:0] dchar,
                                 input logic hreq, input logic [6:0] hchar,
                                 input logic [3:0] hrow);
        rst_i       = rst;
        disp_req_i  = dreq;
        disp_char_i = dchar;
        host_req_i  = hreq;
        host_char_i = hchar;
        host_row_i  = hrow;
        @(negedge clk);
    endtask

    // Holds the request until the ack is seen, keeps it high through the ack cycle.
    task automatic hostRead(input logic [6:0] c, input logic [3:0] r, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            applyStimulus(1'b0, 1'b0, 7'd0, 1'b1, c, r);
            seen = host_ack_o;
        end
        checkOutput({tag, "_ack_seen"}, 128'(seen), 128'(1'b1));
        checkOutput({tag, "_data"}, 128'(host_data_o), 128'({r, c[3:0]}));
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b1, c, r);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 7'd0, 4'd0);
    endtask

    initial begin
        logic       hreq;
        logic [6:0] hchar;
        logic [3:0] hrow;
        logic       dreq;

        rst_i = 1'b1; disp_req_i = 1'b0; disp_char_i = '0;
        host_req_i = 1'b0; host_char_i = '0; host_row_i = '0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 7'h05, 1'b1, 7'h05, 4'd2);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 7'd0, 4'd0);

        for (int k = 0; k < 128; k++) applyStimulus(1'b0, 1'b1, 7'(k), 1'b0, 7'd0, 4'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 7'd0, 4'd0);

        hostRead(7'h25, 4'd3, "t3");

        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 7'(i + 3), 1'b1, 7'h41, 4'd7);
        checkOutput("t4_starve_set", 128'(host_starve_o), 128'(1'b1));
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b1, 7'h41, 4'd7);
        checkOutput("t4_starve_clear", 128'(host_starve_o), 128'(1'b0));
        hostRead(7'h41, 4'd7, "t4");

        applyStimulus(1'b0, 1'b1, 7'h12, 1'b1, 7'h33, 4'd5);
        hostRead(7'h33, 4'd5, "t5");

        applyStimulus(1'b0, 1'b0, 7'd0, 1'b1, 7'h66, 4'd2);
        applyStimulus(1'b1, 1'b0, 7'd0, 1'b0, 7'd0, 4'd0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 7'd0, 4'd0);
        hostRead(7'h27, 4'd9, "t6");

        hreq = 1'b0; hchar = '0; hrow = '0;
        for (int i = 0; i < 600; i++) begin
            if (i < 300) dreq = ($urandom_range(0, 3) != 0);
            else         dreq = ($urandom_range(0, 1) != 0);
            if (host_ack_o) begin
                hreq = 1'b0;
            end else if (!hreq && $urandom_range(0, 3) == 0) begin
                hreq  = 1'b1;
                hchar = 7'($urandom);
                hrow  = 4'($urandom);
            end else if (hreq && $urandom_range(0, 19) == 0) begin
                hreq = 1'b0;
            end
            applyStimulus(($urandom_range(0, 149) == 0), dreq, 7'($urandom), hreq, hchar, hrow);
        end

        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
